// File: rtl/sprite_compositor_pkg.sv
// Shared colour constants, map tile codes and the tile-to-colour lookup
// used by the sprite compositor.
package sprite_compositor_pkg;

    localparam logic [7:0] COLOR_BG     = 8'h00;
    localparam logic [7:0] COLOR_NULL   = 8'h49;
    localparam logic [7:0] COLOR_WALL   = 8'h03;
    localparam logic [7:0] COLOR_PELLET = 8'hf4;

    typedef enum logic [1:0] {
        TILE_WALL   = 2'b00,
        TILE_EMPTY  = 2'b01,
        TILE_PELLET = 2'b10,
        TILE_POWER  = 2'b11
    } tile_t;

    // Power pellets share the pellet colour while lit and vanish otherwise.
    function automatic logic [7:0] tile_color(input tile_t code, input logic power_on);
        logic [7:0] c;
        case (code)
            TILE_WALL:   c = COLOR_WALL;
            TILE_EMPTY:  c = COLOR_NULL;
            TILE_PELLET: c = COLOR_PELLET;
            default:     c = power_on ? COLOR_PELLET : COLOR_NULL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_compositor_sprite_hit.sv
// Registered box test of one square sprite against the current map-relative
// pixel; signed arithmetic lets sprites near the top/left edge clip cleanly.
module sprite_hit
    import sprite_compositor_pkg::*;
#(
    parameter int SPRITE_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] map_x,
    input  logic [10:0] map_y,
    input  logic        in_map,
    input  logic [8:0]  spr_x,
    input  logic [8:0]  spr_y,
    input  logic        spr_en,
    output logic        hit_q
);

    localparam logic signed [11:0] HALF = 12'(SPRITE_W / 2);

    logic signed [11:0] mx, my, sx, sy;
    logic               hit_d;

    always_comb begin
        mx    = $signed({1'b0, map_x});
        my    = $signed({1'b0, map_y});
        sx    = $signed({3'b000, spr_x});
        sy    = $signed({3'b000, spr_y});
        hit_d = spr_en && in_map
             && (mx >= sx - HALF) && (mx < sx + HALF)
             && (my >= sy - HALF) && (my < sy + HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) hit_q <= 1'b0;
        else       hit_q <= hit_d;
    end

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel compositor: map tiles under NUM_SPRITES priority-ordered sprites,
// two-stage pipeline, sprite state shadowed once per frame.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 24,
    parameter int MAP_X0      = 150,
    parameter int MAP_Y0      = 50,
    parameter int MAP_W       = 347,
    parameter int MAP_H       = 405,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BLINK_LOG2  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              x,
    input  logic [10:0]              y,
    input  logic [9*NUM_SPRITES-1:0] spr_x,
    input  logic [9*NUM_SPRITES-1:0] spr_y,
    input  logic [NUM_SPRITES-1:0]   spr_en,
    input  logic [8*NUM_SPRITES-1:0] spr_color,
    output logic [10:0]              map_x,
    output logic [10:0]              map_y,
    input  logic [1:0]               map_pixel,
    output logic [7:0]               rgb,
    output logic                     frame_tick,
    output logic [NUM_SPRITES-1:0]   collision
);

    logic [9*NUM_SPRITES-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [NUM_SPRITES-1:0]   sh_en_q, sh_en_d;
    logic [8*NUM_SPRITES-1:0] sh_color_q, sh_color_d;
    logic [BLINK_LOG2:0]      blink_q, blink_d;
    logic [NUM_SPRITES-1:0]   acc_q, acc_d, collision_q, collision_d, overlap;
    logic                     frame_tick_q, frame_tick_d;
    logic                     active_q, active_d, in_map_q, in_map_d;
    tile_t                    code_q, code_d;
    logic [NUM_SPRITES-1:0]   hit_q;
    logic [7:0]               rgb_q, rgb_d;
    logic                     latch;

    assign map_x = x - 11'(MAP_X0);
    assign map_y = y - 11'(MAP_Y0);

    always_comb begin
        latch    = (x == 11'd0) && (y == 11'(V_ACTIVE));
        active_d = (x < 11'(H_ACTIVE)) && (y < 11'(V_ACTIVE));
        in_map_d = (x >= 11'(MAP_X0)) && (x < 11'(MAP_X0 + MAP_W))
                && (y >= 11'(MAP_Y0)) && (y < 11'(MAP_Y0 + MAP_H));
        code_d   = tile_t'(map_pixel);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_hit
            sprite_hit #(.SPRITE_W(SPRITE_W)) u_hit (
                .clk    (clk),
                .reset  (reset),
                .map_x  (map_x),
                .map_y  (map_y),
                .in_map (in_map_d),
                .spr_x  (sh_x_q[9*g +: 9]),
                .spr_y  (sh_y_q[9*g +: 9]),
                .spr_en (sh_en_q[g]),
                .hit_q  (hit_q[g])
            );
        end
    endgenerate

    // Overlap is judged on the S1 stage; the latch-cycle overlap seeds the new frame.
    always_comb begin
        overlap      = (hit_q[0] && active_q) ? (hit_q & ~NUM_SPRITES'(1)) : '0;
        sh_x_d       = sh_x_q;
        sh_y_d       = sh_y_q;
        sh_en_d      = sh_en_q;
        sh_color_d   = sh_color_q;
        blink_d      = blink_q;
        collision_d  = collision_q;
        acc_d        = acc_q | overlap;
        frame_tick_d = latch;
        if (latch) begin
            sh_x_d      = spr_x;
            sh_y_d      = spr_y;
            sh_en_d     = spr_en;
            sh_color_d  = spr_color;
            blink_d     = blink_q + {{BLINK_LOG2{1'b0}}, 1'b1};
            collision_d = acc_q;
            acc_d       = overlap;
        end
    end

    // Lowest sprite index wins, so scan from the top down and let lower indices overwrite.
    always_comb begin
        rgb_d = tile_color(code_q, ~blink_q[BLINK_LOG2]);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) rgb_d = sh_color_q[8*i +: 8];
        end
        if (!in_map_q) rgb_d = COLOR_NULL;
        if (!active_q) rgb_d = COLOR_BG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_en_q      <= '0;
            sh_color_q   <= '0;
            blink_q      <= '0;
            acc_q        <= '0;
            collision_q  <= '0;
            frame_tick_q <= 1'b0;
            active_q     <= 1'b0;
            in_map_q     <= 1'b0;
            code_q       <= TILE_WALL;
            rgb_q        <= '0;
        end else begin
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_en_q      <= sh_en_d;
            sh_color_q   <= sh_color_d;
            blink_q      <= blink_d;
            acc_q        <= acc_d;
            collision_q  <= collision_d;
            frame_tick_q <= frame_tick_d;
            active_q     <= active_d;
            in_map_q     <= in_map_d;
            code_q       <= code_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized checks of the sprite compositor against a pixel-level
// reference model of map tiles, sprite boxes, blinking and collisions.
module tb_sprite_compositor;

    localparam logic [7:0] C_NULL   = 8'h49;
    localparam logic [7:0] C_WALL   = 8'h03;
    localparam logic [7:0] C_PELLET = 8'hf4;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic [35:0] spr_x, spr_y;
    logic [3:0]  spr_en;
    logic [31:0] spr_color;
    logic [10:0] map_x, map_y;
    logic [1:0]  map_pixel;
    logic [7:0]  rgb;
    logic        frame_tick;
    logic [3:0]  collision;

    sprite_compositor dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_color(spr_color),
        .map_x(map_x), .map_y(map_y), .map_pixel(map_pixel),
        .rgb(rgb), .frame_tick(frame_tick), .collision(collision)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Sprite inputs the bench drives and the model's view of the latched copy.
    int         in_sx[4], in_sy[4];
    bit         in_en[4];
    logic [7:0] in_col[4];
    int         m_sx[4], m_sy[4];
    bit         m_en[4];
    logic [7:0] m_col[4];
    int         m_frames;
    logic [3:0] m_acc, m_coll;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sprites();
        for (int i = 0; i < 4; i++) begin
            spr_x[9*i +: 9]     = 9'(in_sx[i]);
            spr_y[9*i +: 9]     = 9'(in_sy[i]);
            spr_en[i]           = in_en[i];
            spr_color[8*i +: 8] = in_col[i];
        end
    endtask

    task automatic set_sprite(input int i, input int sx, input int sy, input bit en, input logic [7:0] col);
        in_sx[i] = sx; in_sy[i] = sy; in_en[i] = en; in_col[i] = col;
        drive_sprites();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_en[i] = 0; m_col[i] = 8'h00;
        end
        m_frames = 0; m_acc = 4'b0; m_coll = 4'b0;
    endtask

    // Which sprite boxes cover screen pixel (px,py); only pixels inside the map count.
    function automatic logic [3:0] model_hits(input int px, input int py);
        logic [3:0] h = 4'b0;
        int mx = px - 150;
        int my = py - 50;
        if (mx < 0 || mx >= 347 || my < 0 || my >= 405) return 4'b0;
        for (int i = 0; i < 4; i++)
            if (m_en[i] && mx >= m_sx[i] - 12 && mx < m_sx[i] + 12 &&
                my >= m_sy[i] - 12 && my < m_sy[i] + 12) h[i] = 1'b1;
        return h;
    endfunction

    function automatic logic [7:0] model_rgb(input int px, input int py, input logic [1:0] mp);
        logic [3:0] h;
        if (px >= 640 || py >= 480) return 8'h00;
        if (px < 150 || px >= 497 || py < 50 || py >= 455) return C_NULL;
        h = model_hits(px, py);
        for (int i = 0; i < 4; i++) if (h[i]) return m_col[i];
        case (mp)
            2'b00:   return C_WALL;
            2'b01:   return C_NULL;
            2'b10:   return C_PELLET;
            default: return ((m_frames / 16) % 2 == 0) ? C_PELLET : C_NULL;
        endcase
    endfunction

    task automatic idle();
        x = 11'd700; y = 11'd500; map_pixel = 2'b01;
        tick();
    endtask

    task automatic render(input string tag, input int px, input int py, input logic [1:0] mp);
        logic [3:0] h;
        x = 11'(px); y = 11'(py); map_pixel = mp;
        tick();
        tick();
        chk(tag, rgb, model_rgb(px, py, mp));
        h = model_hits(px, py);
        if (h[0]) m_acc = m_acc | (h & 4'b1110);
    endtask

    task automatic frame_latch(input string tag);
        idle();
        x = 11'd0; y = 11'd480;
        tick();
        m_coll = m_acc;
        m_acc  = 4'b0;
        m_frames++;
        for (int i = 0; i < 4; i++) begin
            m_sx[i] = in_sx[i]; m_sy[i] = in_sy[i]; m_en[i] = in_en[i]; m_col[i] = in_col[i];
        end
        chk({tag, "_tick_hi"}, frame_tick, 1'b1);
        idle();
        chk({tag, "_tick_lo"}, frame_tick, 1'b0);
        chk({tag, "_collision"}, collision, m_coll);
    endtask

    initial begin
        reset = 1'b1;
        x = 11'd700; y = 11'd500; map_pixel = 2'b01;
        for (int i = 0; i < 4; i++) set_sprite(i, 0, 0, 1'b0, 8'h00);
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_rgb", rgb, 8'h00);
        chk("reset_collision", collision, 4'b0);
        chk("reset_frame_tick", frame_tick, 1'b0);

        // Latency: the wall pixel must appear exactly two edges after it is applied.
        idle(); idle();
        x = 11'd150; y = 11'd50; map_pixel = 2'b00;
        tick();
        chk("latency_one_cycle", rgb, 8'h00);
        tick();
        chk("latency_two_cycles", rgb, C_WALL);
        render("offscreen_700", 700, 100, 2'b00);
        render("tile_pellet", 300, 300, 2'b10);
        render("tile_empty", 300, 301, 2'b01);

        // Priority between overlapping sprites 0 and 2; disable takes effect only at latch.
        set_sprite(0, 100, 100, 1'b1, 8'hc1);
        set_sprite(2, 100, 100, 1'b1, 8'hc2);
        frame_latch("prio_latch0");
        render("prio_both", 250, 150, 2'b00);
        set_sprite(0, 100, 100, 1'b0, 8'hc1);
        render("prio_before_latch", 250, 150, 2'b00);
        frame_latch("prio_latch1");
        render("prio_after_latch", 250, 150, 2'b00);

        // Edge clipping of a sprite centred near the map origin.
        set_sprite(2, 0, 0, 1'b0, 8'h00);
        set_sprite(1, 5, 5, 1'b1, 8'hb1);
        frame_latch("clip_latch");
        render("clip_origin", 150, 50, 2'b00);
        render("clip_inner_corner", 166, 66, 2'b00);
        render("clip_past_right", 167, 55, 2'b00);
        render("clip_left_of_map", 149, 50, 2'b00);
        render("clip_far_x340", 490, 55, 2'b00);
        render("clip_far_x346", 496, 60, 2'b00);
        render("clip_far_y", 160, 450, 2'b00);

        // Collision between sprites 0 and 3, then separation.
        set_sprite(1, 0, 0, 1'b0, 8'h00);
        set_sprite(0, 200, 200, 1'b1, 8'hd0);
        set_sprite(3, 210, 205, 1'b1, 8'hd3);
        frame_latch("coll_latch0");
        render("coll_overlap_px", 355, 252, 2'b01);
        set_sprite(3, 50, 300, 1'b1, 8'hd3);
        frame_latch("coll_latch1");
        render("coll_sprite0_px", 350, 250, 2'b01);
        render("coll_sprite3_px", 200, 350, 2'b01);
        frame_latch("coll_latch2");

        // Reset mid-frame with a sprite drawn and a collision pending.
        set_sprite(3, 200, 200, 1'b1, 8'hd3);
        frame_latch("rst_pre_latch0");
        render("rst_pre_overlap", 350, 250, 2'b00);
        frame_latch("rst_pre_latch1");
        x = 11'd350; y = 11'd250; map_pixel = 2'b00;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midreset_rgb", rgb, 8'h00);
            chk("midreset_collision", collision, 4'b0);
            chk("midreset_frame_tick", frame_tick, 1'b0);
        end
        model_reset();
        reset = 1'b0;
        tick();
        chk("postreset_rgb_flushed", rgb, 8'h00);
        tick();
        chk("postreset_no_sprite", rgb, C_WALL);

        // Power pellet blink across frames with no sprites.
        for (int i = 0; i < 4; i++) set_sprite(i, 0, 0, 1'b0, 8'h00);
        render("blink_frame0", 300, 200, 2'b11);
        for (int f = 0; f < 34; f++) begin
            frame_latch("blink_latch");
            render("blink_pixel", 300, 200, 2'b11);
        end

        // Randomized frames: random sprites, pixels biased to sprite neighbourhoods.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++)
                set_sprite(i, $urandom_range(0, 346), $urandom_range(0, 404),
                           1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
            if (f % 2 == 0) set_sprite(1, in_sx[0] + 6, in_sy[0] - 8, 1'b1, in_col[1]);
            frame_latch("rand_latch");
            for (int p = 0; p < 40; p++) begin
                int px, py, j;
                if ($urandom_range(0, 2) != 0) begin
                    j  = $urandom_range(0, 3);
                    px = 150 + in_sx[j] + int'($urandom_range(0, 30)) - 15;
                    py = 50 + in_sy[j] + int'($urandom_range(0, 30)) - 15;
                end else begin
                    px = $urandom_range(0, 700);
                    py = $urandom_range(0, 500);
                end
                render("rand_pixel", px, py, 2'($urandom_range(0, 3)));
            end
        end
        frame_latch("rand_final_latch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
